// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Holds the digit count, the active-low hex glyph table, the blank codes, the
// load-word struct and a helper that produces the active-low anode select.
package seg7_pkg;

  localparam int DIGITS = 8;

  // All segments / all anodes released (display dark).
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low glyphs {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // One display word together with its per-digit masks.
  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  blank;
    logic [7:0]  dp;
  } word_t;

  // Active-low one-hot anode for digit idx.
  function automatic logic [7:0] an_select(input logic [2:0] idx);
    an_select = ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load bus into the scan driver.
//   value       : 32-bit word, digit i = value[4i+3:4i]
//   value_valid : one-cycle strobe that captures value and both masks
//   blank_mask  : bit i = 1 -> digit i dark
//   dp_mask     : bit i = 1 -> decimal point lit on digit i
// master drives the bus, slave (the scan driver) samples it.
interface seg7_scan_driver_if;

  logic [31:0]                 value;
  logic                        value_valid;
  logic [seg7_pkg::DIGITS-1:0] blank_mask;
  logic [seg7_pkg::DIGITS-1:0] dp_mask;

  modport master (output value, output value_valid, output blank_mask, output dp_mask);
  modport slave  (input  value, input  value_valid, input  blank_mask, input  dp_mask);

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex-to-7-segment decoder.
//   hex_i : 4-bit nibble
//   seg_o : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Tear-free time-multiplexed driver for an 8-digit common-anode 7-seg display.
// A loaded word waits in a pending register and is moved into the displayed
// (shadow) copy only at the end of the digit-7 slot, so a frame never mixes two
// words. Each digit slot starts with DEAD_CYC cycles of all anodes off.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-low
//   load_if    : load bus (value, value_valid, blank_mask, dp_mask)
//   an         : anode enables, active-low, at most one low
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_done : one-cycle pulse following the last cycle of the digit-7 slot
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  seg7_scan_driver_if.slave        load_if,
  output logic [7:0]               an,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic                     frame_done
);

  localparam int              CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  word_t            pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  word_t            sh_q, sh_d;
  word_t            strobe_s;
  logic             slot_end_s, boundary_s;
  logic [3:0]       digit_s;
  logic [6:0]       glyph_s;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d, frame_done_q;

  assign strobe_s   = '{val: load_if.value, blank: load_if.blank_mask, dp: load_if.dp_mask};
  assign slot_end_s = (cnt_q == CNT_MAX);
  assign boundary_s = slot_end_s && (idx_q == 3'(DIGITS - 1));

  // Slot timer and digit index; idx wraps 7 -> 0 naturally in 3 bits.
  always_comb begin
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Pending/shadow update: the shadow only changes on the frame boundary, and a
  // strobe landing on the boundary itself bypasses the pending stage.
  always_comb begin
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    sh_d        = sh_q;
    if (boundary_s && load_if.value_valid) begin
      sh_d        = strobe_s;
      pend_flag_d = 1'b0;
    end else if (boundary_s && pend_flag_q) begin
      sh_d        = pend_q;
      pend_flag_d = 1'b0;
    end else if (load_if.value_valid) begin
      pend_d      = strobe_s;
      pend_flag_d = 1'b1;
    end else begin
      pend_flag_d = pend_flag_q;
    end
  end

  assign digit_s = sh_q.val[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .hex_i (digit_s),
    .seg_o (glyph_s)
  );

  // Next display drive from the current slot state; dark during dead time or blanking.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((cnt_q < CNT_DEAD) || sh_q.blank[idx_q]) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = an_select(idx_q);
      seg_d = glyph_s;
      dp_d  = ~sh_q.dp[idx_q];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      sh_q         <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      sh_q         <= sh_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= boundary_s;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, DEAD_CYC=1.
// Each frame is 32 cycles; outputs observed after the edge ending frame cycle c
// reflect slot digit c/4, position c%4 (position 0 is the dark dead cycle).
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int last_fd = -1;

  seg7_scan_driver_if lif ();

  seg7_scan_driver #(.REFRESH_DIV(4), .DEAD_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_if    (lif),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Run n_cyc cycles of one frame, optionally strobing a word at frame cycle st_at,
  // and compare every cycle against the expected glyphs and masks.
  task automatic run_frame(input string nm, input logic [6:0] g [8], input logic [7:0] blank,
                           input logic [7:0] dpm, input int st_at, input logic [31:0] st_val,
                           input logic [7:0] st_blank, input logic [7:0] st_dp, input int n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      int         idx;
      logic       lit;
      logic [7:0] an_e;
      logic [6:0] seg_e;
      logic       dp_e;
      if (c == st_at) begin
        lif.value       = st_val;
        lif.blank_mask  = st_blank;
        lif.dp_mask     = st_dp;
        lif.value_valid = 1'b1;
      end else begin
        lif.value_valid = 1'b0;
      end
      tick();
      idx   = c / 4;
      lit   = ((c % 4) != 0) && !blank[idx];
      an_e  = 8'hFF;
      seg_e = 7'h7F;
      dp_e  = 1'b1;
      if (lit) begin
        an_e  = 8'h01 << idx;
        an_e  = ~an_e;
        seg_e = g[idx];
        dp_e  = ~dpm[idx];
      end
      chk($sformatf("%s c%0d an", nm, c), {24'd0, an}, {24'd0, an_e});
      chk($sformatf("%s c%0d seg", nm, c), {25'd0, seg}, {25'd0, seg_e});
      chk($sformatf("%s c%0d dp", nm, c), {31'd0, dp}, {31'd0, dp_e});
      chk($sformatf("%s c%0d frame_done", nm, c), {31'd0, frame_done}, {31'd0, (c == 31)});
      if (frame_done) begin
        if (last_fd < 0) chk("fd first at 32", cyc, 32);
        else             chk("fd period 32", cyc - last_fd, 32);
        last_fd = cyc;
      end
    end
    lif.value_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] g_zero [8];
    logic [6:0] g_w1 [8];
    logic [6:0] g_ff [8];
    logic [6:0] g_5 [8];
    g_zero = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    g_w1   = '{7'h0E, 7'h08, 7'h10, 7'h00, 7'h30, 7'h24, 7'h79, 7'h40};
    g_ff   = '{7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
    g_5    = '{7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    lif.value = 32'd0; lif.value_valid = 1'b0; lif.blank_mask = 8'd0; lif.dp_mask = 8'd0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("reset an", {24'd0, an}, 32'h0000_00FF);
    chk("reset seg", {25'd0, seg}, 32'h0000_007F);
    chk("reset dp", {31'd0, dp}, 32'd1);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);

    reset = 1'b1;
    cyc = 0;
    // Frame 0 shows zeros even though a word is loaded mid-frame.
    run_frame("f0", g_zero, 8'h00, 8'h00, 5, 32'h0123_89AF, 8'h00, 8'h00, 32);
    // Frame 1 shows the loaded word; an all-F load in digit 3 must not tear it.
    run_frame("f1", g_w1, 8'h00, 8'h00, 13, 32'hFFFF_FFFF, 8'h00, 8'h00, 32);
    // Frame 2 shows all F; strobe exactly on the boundary cycle.
    run_frame("f2", g_ff, 8'h00, 8'h00, 31, 32'h0000_0005, 8'h80, 8'h01, 32);
    // Frame 3 shows the boundary word at once, digit 7 blanked, dp on digit 0.
    run_frame("f3", g_5, 8'h80, 8'h01, -1, 32'd0, 8'd0, 8'd0, 32);
    // Frame 4: load a word that reset must discard, then reset during digit 5.
    run_frame("f4", g_5, 8'h80, 8'h01, 10, 32'h7777_7777, 8'h00, 8'h00, 22);

    reset = 1'b0;
    #1;
    chk("midreset an", {24'd0, an}, 32'h0000_00FF);
    chk("midreset seg", {25'd0, seg}, 32'h0000_007F);
    chk("midreset dp", {31'd0, dp}, 32'd1);
    chk("midreset frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);

    reset = 1'b1;
    cyc = 0;
    last_fd = -1;
    // Restart from digit 0 showing zeros; the discarded word never appears.
    run_frame("r0", g_zero, 8'h00, 8'h00, -1, 32'd0, 8'd0, 8'd0, 32);
    run_frame("r1", g_zero, 8'h00, 8'h00, -1, 32'd0, 8'd0, 8'd0, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
